reg_wb_queue: RTL and testbench
===============================

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer offers a write-back request.
REQ-005 in_ready  output  1  queue can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 in_addr  input  5  destination register number.
REQ-007 in_ppp  input  3  partial-write select: 000 full, 001 bits [0:31], 010 bits [32:63], 011 even bytes, 100 odd bytes; 101-111 reserved.
REQ-008 in_data  input  64  write data, bit 0 = MSB.
REQ-009 wb_hold  input  1  inhibits issue to the register file this cycle.
REQ-010 wr_en, ppp[3], wr_addr[5], wr_data[64]  outputs  register-file write port, driven from queue head.
REQ-011 q_addr1, q_addr2  input  5 each  operand read addresses being decoded.
REQ-012 hz_r1, hz_r2  output  1 each  read address has a pending write not yet issued.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 err_ppp  output  1  one-cycle pulse for a rejected reserved ppp.

Function
REQ-015 Queue SHALL be FIFO; issue order SHALL equal acceptance order.
REQ-016 in_ready SHALL equal (count < DEPTH), independent of same-cycle issue.
REQ-017 Accepted request with in_addr = 0 and legal ppp SHALL be discarded, count unchanged, no error.
REQ-018 Accepted request with ppp 101-111 SHALL be discarded; err_ppp SHALL be 1 in the following cycle only (including when in_addr = 0).
REQ-019 Accepted legal request with in_addr != 0 SHALL be stored; earliest issue is the cycle after acceptance (no bypass of an empty queue).
REQ-020 wr_en SHALL equal (count != 0) && !wb_hold; wr_addr, ppp, wr_data SHALL reflect the head entry combinationally.
REQ-021 Head entry SHALL be popped at the rising edge where wr_en = 1; the register file accepts every write unconditionally.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 When wb_hold = 1 the queue SHALL retain contents; pushes continue until full.
REQ-024 hz_rN SHALL be 1 iff q_addrN != 0 and a valid entry other than the head-being-issued-this-cycle has address q_addrN (the register file forwards the issuing write internally).
REQ-025 hz_rN SHALL be combinational from queue state, q_addrN and wb_hold; same-cycle in_* SHALL NOT affect it.
REQ-026 Data SHALL be stored unmodified; byte-lane merge is performed by the register file per ppp.

Reset
REQ-027 With rst = 1 at a rising edge: count = 0, pointers = 0, all entries invalid, err_ppp = 0.
REQ-028 While count = 0 after reset: wr_en = 0, hz_r1 = hz_r2 = 0, in_ready = 1.
REQ-029 Reset mid-operation SHALL flush pending entries; flushed entries SHALL never be written; a request offered during the reset cycle SHALL be dropped.

Configuration
REQ-030 Macro REG_WB_QUEUE_HAZARD_EN: defined -> hz_r1/hz_r2 computed per REQ-024/025; undefined -> hz_r1 = hz_r2 = 0 constant, address comparators not instantiated, ports retained.

Verification
REQ-031 Reset, then push {addr 5, ppp 000, data 0x0123456789ABCDEF}, wb_hold 0 -> next cycle wr_en 1, wr_addr 5, wr_data 0x0123456789ABCDEF; following cycle count 0, wr_en 0.
REQ-032 wb_hold 1, push addrs 1,2,3,4 -> count 4, in_ready 0, fifth offer not accepted; release hold -> writes issue 1,2,3,4 on 4 consecutive cycles.
REQ-033 Push addr 0 ppp 000, then addr 7 ppp 110 -> neither issued, count stays 0, err_ppp high exactly one cycle after second push.
REQ-034 (HAZARD_EN) hold 1, queue addr 9; q_addr1 9, q_addr2 0 -> hz_r1 1, hz_r2 0; drop hold -> hz_r1 0 during issue cycle.
REQ-035 Full queue with hold 1, assert rst one cycle -> count 0, no write ever issued for flushed entries, in_ready 1.
REQ-036 Continuous push with hold 0 for 20 cycles, alternating ppp 011/100 -> one write per cycle, count stays at 1, order and ppp preserved.

Source files
------------

// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if
//   Producer-side handshake bundle for the register write-back queue.
//   in_valid  producer offers a write-back request
//   in_ready  queue can accept (transfer when in_valid && in_ready at clk rise)
//   in_addr   destination register number
//   in_ppp    partial-write select (000 full, 001 bits [0:31], 010 bits [32:63],
//             011 even bytes, 100 odd bytes, 101-111 reserved)
//   in_data   write data, bit 0 is the MSB
// Modports: master = producer, slave = queue.
interface reg_wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [2:0]  in_ppp;
  logic [0:63] in_data;

  modport master (
    output in_valid, in_addr, in_ppp, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_addr, in_ppp, in_data,
    output in_ready
  );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue
//   In-order write-back queue between an execution pipeline and a register
//   file write port. Requests are accepted through bus_if, stored in a FIFO
//   of DEPTH entries, and issued from the head one per cycle unless wb_hold_i
//   is asserted. Writes to register 0 are silently dropped; requests with a
//   reserved ppp code are dropped and flagged with a one-cycle err_ppp_o.
//   Optional read-after-write hazard detection for two operand addresses.
//
// Configuration macro: REG_WB_QUEUE_HAZARD_EN
//   defined   -> hz_r1_o / hz_r2_o report pending writes to q_addr1_i / q_addr2_i
//   undefined -> hz_r1_o = hz_r2_o = 0, no address comparators
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   bus_if        producer handshake (slave modport)
//   wb_hold_i     inhibits issue to the register file this cycle
//   wr_en_o       register-file write enable (head valid and not held)
//   ppp_o         partial-write select of head entry
//   wr_addr_o     destination register of head entry
//   wr_data_o     write data of head entry (bit 0 = MSB)
//   q_addr1_i/2_i operand read addresses under decode
//   hz_r1_o/2_o   operand has a pending, not-yet-issued write
//   count_o       current occupancy
//   err_ppp_o     one-cycle pulse after a reserved ppp was accepted
module reg_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_wb_queue_if.slave           bus_if,
  input  logic                    wb_hold_i,
  output logic                    wr_en_o,
  output logic [2:0]              ppp_o,
  output logic [4:0]              wr_addr_o,
  output logic [0:63]             wr_data_o,
  input  logic [4:0]              q_addr1_i,
  input  logic [4:0]              q_addr2_i,
  output logic                    hz_r1_o,
  output logic                    hz_r2_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    err_ppp_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]        addr_q [DEPTH];
  logic [2:0]        ppp_q  [DEPTH];
  logic [0:63]       data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_ppp_q, err_ppp_d;

  logic accept;
  logic ppp_legal;
  logic push;
  logic pop;

  // Readiness depends only on occupancy, so a full queue stalls the producer
  // even when the head is leaving this cycle.
  assign bus_if.in_ready = (count_q < CW'(DEPTH));
  assign accept          = bus_if.in_valid && bus_if.in_ready;
  assign ppp_legal       = (bus_if.in_ppp <= 3'd4);
  assign push            = accept && ppp_legal && (bus_if.in_addr != 5'd0);
  assign pop             = (count_q != '0) && !wb_hold_i;

  assign wr_en_o   = pop;
  assign wr_addr_o = addr_q[rd_ptr_q];
  assign ppp_o     = ppp_q[rd_ptr_q];
  assign wr_data_o = data_q[rd_ptr_q];
  assign count_o   = count_q;
  assign err_ppp_o = err_ppp_q;

  always_comb begin
    valid_d   = valid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_ppp_d = accept && !ppp_legal;

    // A push never targets the head slot while it is being popped: push needs
    // a free slot and pop needs a non-empty queue, so the slots differ.
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ppp_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ppp_q <= err_ppp_d;
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_q[wr_ptr_q] <= bus_if.in_addr;
      ppp_q[wr_ptr_q]  <= bus_if.in_ppp;
      data_q[wr_ptr_q] <= bus_if.in_data;
    end
  end

`ifdef REG_WB_QUEUE_HAZARD_EN
  // The head issuing this cycle is forwarded inside the register file, so it
  // is excluded; later entries with the same address still count.
  always_comb begin
    hz_r1_o = 1'b0;
    hz_r2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(pop && (AW'(i) == rd_ptr_q))) begin
        if (addr_q[i] == q_addr1_i) hz_r1_o = 1'b1;
        if (addr_q[i] == q_addr2_i) hz_r2_o = 1'b1;
      end
    end
    if (q_addr1_i == 5'd0) hz_r1_o = 1'b0;
    if (q_addr2_i == 5'd0) hz_r2_o = 1'b0;
  end
`else
  logic unused_q_addr;
  assign unused_q_addr = ^{q_addr1_i, q_addr2_i};
  assign hz_r1_o = 1'b0;
  assign hz_r2_o = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue
//   Directed bench for reg_wb_queue. Stimulus pushes the expected write into
//   a scoreboard queue; a negedge monitor pops and compares every issued
//   register-file write. Cycle-specific state (count, ready, error, hazard)
//   is checked 1 time unit after the rising edge.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

`ifdef REG_WB_QUEUE_HAZARD_EN
  localparam bit HzEn = 1'b1;
`else
  localparam bit HzEn = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [2:0]  ppp;
    logic [0:63] data;
  } wbEntry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbHold;
  logic          wrEn;
  logic [2:0]    wrPpp;
  logic [4:0]    wrAddr;
  logic [0:63]   wrData;
  logic [4:0]    qAddr1;
  logic [4:0]    qAddr2;
  logic          hz1;
  logic          hz2;
  logic [CW-1:0] count;
  logic          errPpp;

  int checkCount = 0;
  int passCount  = 0;
  wbEntry_t expQ[$];

  reg_wb_queue_if busIf();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_if    (busIf),
    .wb_hold_i (wbHold),
    .wr_en_o   (wrEn),
    .ppp_o     (wrPpp),
    .wr_addr_o (wrAddr),
    .wr_data_o (wrData),
    .q_addr1_i (qAddr1),
    .q_addr2_i (qAddr2),
    .hz_r1_o   (hz1),
    .hz_r2_o   (hz2),
    .count_o   (count),
    .err_ppp_o (errPpp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Offer one request for one cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [2:0] ppp,
                               input logic [0:63] data, input bit expectStore);
    wbEntry_t e;
    busIf.in_valid = 1'b1;
    busIf.in_addr  = addr;
    busIf.in_ppp   = ppp;
    busIf.in_data  = data;
    if (expectStore) begin
      e.addr = addr;
      e.ppp  = ppp;
      e.data = data;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    busIf.in_valid = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every issued write must match the oldest expected one.
  always @(negedge clk) begin
    wbEntry_t e;
    if (wrEn === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected write wr_en", {63'd0, wrEn}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("write wr_addr", {59'd0, wrAddr}, {59'd0, e.addr});
        checkOutput("write ppp", {61'd0, wrPpp}, {61'd0, e.ppp});
        checkOutput("write wr_data", wrData, e.data);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    wbHold         = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.in_addr  = 5'd0;
    busIf.in_ppp   = 3'd0;
    busIf.in_data  = 64'd0;
    qAddr1         = 5'd5;
    qAddr2         = 5'd9;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset count", {61'd0, count}, 64'd0);
    checkOutput("reset wr_en", {63'd0, wrEn}, 64'd0);
    checkOutput("reset in_ready", {63'd0, busIf.in_ready}, 64'd1);
    checkOutput("reset err_ppp", {63'd0, errPpp}, 64'd0);
    checkOutput("reset hz_r1", {63'd0, hz1}, 64'd0);
    checkOutput("reset hz_r2", {63'd0, hz2}, 64'd0);
    rst = 1'b0;

    $display("[TB] single push and issue");
    applyStimulus(5'd5, 3'b000, 64'h0123456789ABCDEF, 1'b1);
    checkOutput("single count", {61'd0, count}, 64'd1);
    checkOutput("single wr_en", {63'd0, wrEn}, 64'd1);
    checkOutput("single wr_addr", {59'd0, wrAddr}, 64'd5);
    checkOutput("single wr_data", wrData, 64'h0123456789ABCDEF);
    stepCycle();
    checkOutput("single drained count", {61'd0, count}, 64'd0);
    checkOutput("single drained wr_en", {63'd0, wrEn}, 64'd0);

    $display("[TB] fill under hold, then release");
    wbHold = 1'b1;
    for (int i = 1; i <= 4; i++)
      applyStimulus(5'(i), 3'b000, {32'hA5A50000 + i, 32'h5A5A0000 + i}, 1'b1);
    checkOutput("full count", {61'd0, count}, 64'd4);
    checkOutput("full in_ready", {63'd0, busIf.in_ready}, 64'd0);
    checkOutput("full wr_en held", {63'd0, wrEn}, 64'd0);
    applyStimulus(5'd5, 3'b000, 64'hDEADBEEFDEADBEEF, 1'b0);
    checkOutput("fifth offer count", {61'd0, count}, 64'd4);
    wbHold = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain wr_en", {63'd0, wrEn}, 64'd1);
      checkOutput("drain wr_addr", {59'd0, wrAddr}, 64'(i));
      stepCycle();
    end
    checkOutput("drain end count", {61'd0, count}, 64'd0);
    checkOutput("drain end wr_en", {63'd0, wrEn}, 64'd0);

    $display("[TB] discarded requests");
    applyStimulus(5'd0, 3'b000, 64'h1111111111111111, 1'b0);
    checkOutput("addr0 count", {61'd0, count}, 64'd0);
    checkOutput("addr0 err_ppp", {63'd0, errPpp}, 64'd0);
    applyStimulus(5'd7, 3'b110, 64'h2222222222222222, 1'b0);
    checkOutput("reserved ppp err_ppp", {63'd0, errPpp}, 64'd1);
    checkOutput("reserved ppp count", {61'd0, count}, 64'd0);
    checkOutput("reserved ppp wr_en", {63'd0, wrEn}, 64'd0);
    stepCycle();
    checkOutput("err_ppp one cycle", {63'd0, errPpp}, 64'd0);
    applyStimulus(5'd0, 3'b111, 64'h3333333333333333, 1'b0);
    checkOutput("addr0 reserved err_ppp", {63'd0, errPpp}, 64'd1);
    checkOutput("addr0 reserved count", {61'd0, count}, 64'd0);
    stepCycle();

    $display("[TB] hazard detection");
    wbHold = 1'b1;
    qAddr1 = 5'd9;
    qAddr2 = 5'd0;
    applyStimulus(5'd9, 3'b000, 64'h0909090909090909, 1'b1);
    #1;
    checkOutput("hazard held hz_r1", {63'd0, hz1}, {63'd0, HzEn});
    checkOutput("hazard held hz_r2", {63'd0, hz2}, 64'd0);
    wbHold = 1'b0;
    #1;
    checkOutput("hazard issue wr_en", {63'd0, wrEn}, 64'd1);
    checkOutput("hazard issue hz_r1", {63'd0, hz1}, 64'd0);
    stepCycle();
    checkOutput("hazard after count", {61'd0, count}, 64'd0);
    wbHold = 1'b1;
    qAddr2 = 5'd3;
    applyStimulus(5'd9, 3'b001, 64'h9999000099990000, 1'b1);
    applyStimulus(5'd9, 3'b010, 64'h0000999900009999, 1'b1);
    #1;
    checkOutput("hazard other addr hz_r2", {63'd0, hz2}, 64'd0);
    wbHold = 1'b0;
    #1;
    checkOutput("hazard second entry hz_r1", {63'd0, hz1}, {63'd0, HzEn});
    stepCycle();
    stepCycle();
    checkOutput("hazard drained count", {61'd0, count}, 64'd0);
    checkOutput("hazard drained hz_r1", {63'd0, hz1}, 64'd0);

    $display("[TB] reset flush");
    wbHold = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(5'(20 + i), 3'b000, {32'hF1F10000 + i, 32'h0}, 1'b1);
    checkOutput("flush pre count", {61'd0, count}, 64'd4);
    rst = 1'b1;
    applyStimulus(5'd12, 3'b000, 64'h1212121212121212, 1'b0);
    rst = 1'b0;
    expQ.delete();
    checkOutput("flush count", {61'd0, count}, 64'd0);
    checkOutput("flush in_ready", {63'd0, busIf.in_ready}, 64'd1);
    checkOutput("flush wr_en", {63'd0, wrEn}, 64'd0);
    wbHold = 1'b0;
    repeat (4) stepCycle();
    checkOutput("flush later count", {61'd0, count}, 64'd0);

    $display("[TB] streaming 20 requests");
    wbHold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'(i + 1), (i % 2 == 1) ? 3'b100 : 3'b011,
                    {32'hC0DE0000 + i, 32'(i * 3)}, 1'b1);
      checkOutput("stream count", {61'd0, count}, 64'd1);
    end
    stepCycle();
    checkOutput("stream end count", {61'd0, count}, 64'd0);

    for (int k = 0; k < 10 && expQ.size() != 0; k++) stepCycle();
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
